// File: rtl/stack_arb_pkg.sv
// stack_arb_pkg: shared FSM states, op encoding and default widths for stack_arbiter.
package stack_arb_pkg;
  typedef enum logic [1:0] {IDLE, PUSH, POP_RD, POP_RSP} state_e;
  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP = 1'b0;
  localparam int DEF_DW = 8;
  localparam int DEF_AW = 8;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-request round-robin arbiter with a registered last-grant pointer.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic       gnt_vld,
  output logic       gnt_id
);
  logic last_q, last_d;
  always_comb begin
    gnt_vld = en & |req;
    gnt_id = (req == 2'b11) ? ~last_q : req[1];
    last_d = gnt_vld ? gnt_id : last_q;
  end
  // Reset as if port 1 won last, so port 0 is favoured first.
  always_ff @(posedge clk or posedge rst)
    if (rst) last_q <= 1'b1;
    else last_q <= last_d;
endmodule

// File: rtl/stack_arbiter.sv
// stack_arbiter: two-port PUSH/POP sequencer for a single-port stack RAM.
// Optional STACK_ARB_FAULT_EN adds a sticky fault flag with fault_clr.
module stack_arbiter
  import stack_arb_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          op0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic          err0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          op1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic          err1,
  output logic [DW-1:0] rdata1,
  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW:0]   count,
`ifdef STACK_ARB_FAULT_EN
  output logic          fault,
  input  logic          fault_clr,
`endif
  output logic          full,
  output logic          empty
);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  state_e state_q, state_d;
  logic id_q, id_d, op_q, op_d;
  logic [DW-1:0] data_q, data_d, rd;
  logic [AW:0] count_q, count_d, cnt_m1;
  logic ack, err, gnt_vld, gnt_id;
  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (state_q == IDLE),
    .req     ({req1, req0}),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );
  assign count = count_q;
  assign full = count_q == DEPTH;
  assign empty = count_q == '0;
  assign cnt_m1 = count_q - 1'b1;
  always_comb begin
    state_d = state_q;
    id_d = id_q;
    op_d = op_q;
    data_d = data_q;
    count_d = count_q;
    ack = 1'b0;
    err = 1'b0;
    rd = '0;
    mem_we = 1'b0;
    mem_re = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: if (gnt_vld) begin
        id_d = gnt_id;
        op_d = gnt_id ? op1 : op0;
        data_d = gnt_id ? wdata1 : wdata0;
        state_d = (op_d == OP_PUSH) ? PUSH : POP_RD;
      end
      PUSH: begin
        ack = 1'b1;
        err = full;
        mem_we = ~full;
        mem_addr = full ? '0 : count_q[AW-1:0];
        mem_wdata = full ? '0 : data_q;
        count_d = count_q + {{AW{1'b0}}, ~full};
        state_d = IDLE;
      end
      POP_RD: begin
        ack = empty;
        err = empty;
        mem_re = ~empty;
        mem_addr = empty ? '0 : cnt_m1[AW-1:0];
        count_d = empty ? count_q : cnt_m1;
        state_d = empty ? IDLE : POP_RSP;
      end
      POP_RSP: begin
        ack = 1'b1;
        rd = mem_rdata;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign ack0 = ack & ~id_q;
  assign ack1 = ack & id_q;
  assign err0 = err & ~id_q;
  assign err1 = err & id_q;
  assign rdata0 = ack0 ? rd : '0;
  assign rdata1 = ack1 ? rd : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      id_q <= 1'b0;
      op_q <= OP_POP;
      data_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      id_q <= id_d;
      op_q <= op_d;
      data_q <= data_d;
      count_q <= count_d;
    end
`ifdef STACK_ARB_FAULT_EN
  logic fault_q, fault_d;
  assign fault_d = err ? 1'b1 : fault_clr ? 1'b0 : fault_q;
  assign fault = fault_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) fault_q <= 1'b0;
    else fault_q <= fault_d;
`endif
endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: directed and random PUSH/POP traffic checked against a queue-based stack model.
module tb_stack_arbiter;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int DEPTH = 1 << AW;
  logic clk = 1'b0, rst = 1'b0;
  logic req0 = 0, op0 = 0, req1 = 0, op1 = 0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0, rdata0, rdata1, mem_wdata, mem_rdata;
  logic ack0, err0, ack1, err1, mem_we, mem_re, full, empty;
  logic [AW-1:0] mem_addr;
  logic [AW:0] count;
`ifdef STACK_ARB_FAULT_EN
  logic fault, fault_clr = 1'b0;
`endif
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] model [$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end
  stack_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .wdata0(wdata0), .ack0(ack0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .op1(op1), .wdata1(wdata1), .ack1(ack1), .err1(err1), .rdata1(rdata1),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .count(count),
`ifdef STACK_ARB_FAULT_EN
    .fault(fault), .fault_clr(fault_clr),
`endif
    .full(full), .empty(empty)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_status(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(model.size()));
    chk({tag, "_empty"}, 32'(empty), 32'(model.size() == 0));
    chk({tag, "_full"}, 32'(full), 32'(model.size() == DEPTH));
  endtask
  task automatic set_req(input int p, input logic v, input logic op, input logic [DW-1:0] d);
    if (p == 0) begin req0 = v; op0 = op; wdata0 = d; end
    else begin req1 = v; op1 = op; wdata1 = d; end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_ack", {ack0, ack1, err0, err1}, 0);
    chk("rst_mem", {mem_we, mem_re, mem_addr, mem_wdata}, 0);
    chk("rst_rdata", {rdata0, rdata1}, 0);
    chk("rst_cnt", {count, empty, full}, {9'd0, 1'b1, 1'b0});
    @(posedge clk); #1;
    rst = 1'b0;
    model.delete();
  endtask
  // Starts just after a clock edge with the DUT idle; leaves it likewise.
  task automatic xact(input int p, input logic op, input logic [DW-1:0] d);
    int n;
    logic a, o, e;
    logic [DW-1:0] r;
    n = model.size();
    set_req(p, 1'b1, op, d);
    @(posedge clk); @(negedge clk);
    a = p ? ack1 : ack0; o = p ? ack0 : ack1; e = p ? err1 : err0;
    chk("other_ack", 32'(o), 0);
    if (op) begin
      chk("push_ack", 32'(a), 1);
      chk("push_err", 32'(e), 32'(n == DEPTH));
      chk("push_we", 32'(mem_we), 32'(n != DEPTH));
      if (n != DEPTH) begin
        chk("push_addr", 32'(mem_addr), 32'(n));
        chk("push_wdata", 32'(mem_wdata), 32'(d));
        model.push_back(d);
      end
    end else if (n == 0) begin
      r = p ? rdata1 : rdata0;
      chk("upop_ack_err", {a, e}, 2'b11);
      chk("upop_rdata", 32'(r), 0);
      chk("upop_re", 32'(mem_re), 0);
    end else begin
      chk("pop_rd", {mem_re, a}, 2'b10);
      chk("pop_addr", 32'(mem_addr), 32'(n - 1));
      @(posedge clk); @(negedge clk);
      a = p ? ack1 : ack0; e = p ? err1 : err0; r = p ? rdata1 : rdata0;
      chk("pop_ack_err", {a, e}, 2'b10);
      chk("pop_rdata", 32'(r), 32'(model[$]));
      chk("pop_other_rdata", 32'(p ? rdata0 : rdata1), 0);
      void'(model.pop_back());
    end
    @(posedge clk); #1;
    set_req(p, 1'b0, 1'b0, '0);
    chk_status("post");
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    @(posedge clk); #1;
    do_reset();
    xact(0, 1'b1, 8'h11);
    xact(0, 1'b1, 8'h22);
    xact(0, 1'b1, 8'h33);
    xact(0, 1'b0, '0);
    xact(0, 1'b0, '0);
    xact(0, 1'b0, '0);
    xact(1, 1'b0, '0);
    for (int i = 0; i < DEPTH; i++) xact(i % 2, 1'b1, 8'($urandom));
    xact(0, 1'b1, 8'hAA);
    xact(1, 1'b0, '0);
    do_reset();
    set_req(0, 1'b1, 1'b1, 8'h01);
    set_req(1, 1'b1, 1'b1, 8'h02);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); @(negedge clk);
      chk("rr_ack", {ack1, ack0}, (i % 2) ? 2'b10 : 2'b01);
      chk("rr_wdata", 32'(mem_wdata), (i % 2) ? 32'h02 : 32'h01);
      model.push_back((i % 2) ? 8'h02 : 8'h01);
      @(posedge clk);
    end
    #1;
    set_req(0, 1'b0, 1'b0, '0);
    set_req(1, 1'b0, 1'b0, '0);
    @(posedge clk); #1;
    chk_status("rr");
    set_req(0, 1'b1, 1'b0, '0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_out", {ack0, ack1, err0, err1, mem_re, mem_we}, 0);
    chk("abort_cnt", {count, empty}, {9'd0, 1'b1});
    @(posedge clk); #1;
    rst = 1'b0;
    set_req(0, 1'b0, 1'b0, '0);
    model.delete();
    xact(0, 1'b1, 8'h5A);
`ifdef STACK_ARB_FAULT_EN
    do_reset();
    chk("fault_rst", 32'(fault), 0);
    xact(1, 1'b0, '0);
    chk("fault_set", 32'(fault), 1);
    set_req(1, 1'b1, 1'b0, '0);
    @(posedge clk); #1;
    fault_clr = 1'b1;
    @(posedge clk); #1;
    fault_clr = 1'b0;
    set_req(1, 1'b0, 1'b0, '0);
    chk("fault_set_wins", 32'(fault), 1);
    fault_clr = 1'b1;
    @(posedge clk); #1;
    fault_clr = 1'b0;
    chk("fault_clr", 32'(fault), 0);
`endif
    do_reset();
    for (int i = 0; i < 300; i++)
      xact(int'($urandom_range(0, 1)), $urandom_range(0, 99) < 55, 8'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stack_arbiter.md
# stack_arbiter

Sequencer and two-port arbiter for the 8-bit hardware stack RAM. Owns the stack pointer, turns PUSH/POP requests from two requesters (port 0: instruction datapath, port 1: call/return unit) into single-port RAM write/read cycles, and reports full/empty with overflow/underflow errors. Sits between the requesters and the stack memory; the memory itself stays a plain synchronous RAM.

## Interface
- DW, 8, data width
- AW, 8, RAM address width; DEPTH = 2**AW entries
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req0 / req1  in  1  request, held high until ack
- op0 / op1  in  1  1 = push, 0 = pop; stable while req high
- wdata0 / wdata1  in  DW  push data; stable while req high
- ack0 / ack1  out  1  one-cycle completion pulse
- err0 / err1  out  1  qualifies ack: overflow (push) or underflow (pop)
- rdata0 / rdata1  out  DW  pop data, valid with ack
- mem_we  out  1  RAM write strobe
- mem_re  out  1  RAM read strobe
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, one cycle after mem_re
- count  out  AW+1  current entries, 0..DEPTH
- full / empty  out  1  count==DEPTH / count==0

## Operation
- Reset: state IDLE, count=0, empty=1, full=0, all ack/err/mem strobes 0, rdata* 0, mem_addr/mem_wdata 0, round-robin pointer favours port 0. RAM contents not cleared.
- FSM states: IDLE, PUSH, POP_RD, POP_RSP.
- IDLE: if any req, arbitrate, latch winner id, op, wdata; go PUSH (op=1) or POP_RD (op=0).
- Arbitration: round robin; if both request, the port not granted last wins; single requester always wins.
- PUSH: if full -> no write, ack+err to winner, count unchanged; else mem_we=1, mem_addr=count[AW-1:0], mem_wdata=latched data, ack to winner, count+1. Next IDLE.
- POP_RD: if empty -> no read, ack+err, rdata=0, next IDLE; else mem_re=1, mem_addr=count-1, count-1, next POP_RSP.
- POP_RSP: rdata<winner> = mem_rdata, ack to winner; next IDLE.
- Non-winning port's ack/err/rdata stay 0. rdata* hold 0 except in the ack cycle.
- count arithmetic in AW+1 bits; never wraps (guarded by full/empty checks).
- Requester must drop or re-arm req the cycle after ack; req still high in IDLE after ack is a new request.

## Timing
- Req sampled in IDLE at cycle N (grant registered at end of N).
- Push: mem_we and ack in N+1; count updated at end of N+1; next grant evaluated N+2. Throughput 1 push per 2 cycles.
- Pop: mem_re in N+1, count updated at end of N+1; rdata+ack in N+2; next grant N+3.
- Error responses (full push, empty pop): ack+err in N+1.
- full/empty/count are registered-state derived, reflect updates the cycle after the edge.
- Reset mid-operation: in-flight op aborted, no ack issued; a push in its write cycle may or may not have landed in RAM but count returns to 0.

## Configuration
- STACK_ARB_FAULT_EN defined: adds ports fault (out, 1) and fault_clr (in, 1). fault set on any err pulse, held until fault_clr high at a clock edge; set wins over simultaneous clear. Reset value 0.
- Not defined: ports absent; err* pulses are the only error indication.

## Structure
- Package stack_arb_pkg: state enum (IDLE, PUSH, POP_RD, POP_RSP), OP_PUSH=1/OP_POP=0 constants, default DW/AW.
- Sub-module rr_arb2: two-request round-robin arbiter with registered last-grant pointer, enabled by the FSM only in IDLE.

## Test plan
- Reset, push 0x11,0x22,0x33 on port 0 -> three acks in N+1 each, mem_we addresses 0,1,2, count=3; three pops -> rdata 0x33,0x22,0x11 in N+2, count=0, empty=1.
- Pop on empty from port 1 -> ack1+err1 in N+1, rdata1=0, no mem_re, count stays 0 (fault=1 with STACK_ARB_FAULT_EN).
- Fill DEPTH entries, push 0xAA -> err on ack, no mem_we, count=DEPTH, full=1; pop returns last pushed value.
- req0 and req1 both held high pushing 0x01/0x02 repeatedly -> grants alternate 0,1,0,1, first grant port 0 after reset.
- Assert rst during POP_RD -> no ack, count=0, all outputs 0 next cycle; subsequent push lands at address 0.
- With STACK_ARB_FAULT_EN: underflow then fault_clr in same cycle as a new err -> fault stays 1; clr alone -> 0.
